// File: rtl/freqdiv_pkg.sv
// Shared types and constants for the divided-clock frequency monitor.
// Holds the FSM encoding, the default lock depth and the error counter ceiling.
package freqdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam int         LOCK_CNT_DEF = 4;
  localparam logic [7:0] ERR_CNT_MAX  = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == ERR_CNT_MAX) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/freqdiv_sync.sv
// Two-flop synchronizer that brings the divided clock into the bus clock domain.
module freqdiv_sync (
  input  logic clkin,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/freqdiv_monitor.sv
// Measures period and high time of a divided clock, checks the ratio against n_i,
// and reports lock plus a sticky, saturating error count.
module freqdiv_monitor
  import freqdiv_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [3:0]       n_i,
  input  logic             clkdiv_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             period_vld_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o
);

  localparam int               MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [MC_W-1:0]  MC_ZERO  = {MC_W{1'b0}};
  localparam logic [MC_W-1:0]  LOCK_V   = MC_W'(LOCK_CNT);

  state_t           state_r, state_s;
  logic             sync_s, hist_r, rise_s, fall_s, active_s, match_hit_s, err_ev_s;
  logic [CNT_W-1:0] per_cnt_r, per_cnt_s, hi_cnt_r, hi_cnt_s;
  logic [CNT_W-1:0] period_r, period_s, high_r, high_s;
  logic [MC_W-1:0]  match_r, match_s, match_inc_s;
  logic             vld_r, vld_s, locked_r, locked_s, err_r, err_s;
  logic [7:0]       err_cnt_r, err_cnt_s;

  freqdiv_sync u_sync (
    .clkin (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .d     (clkdiv_i),
    .q     (sync_s)
  );

  // History flop resets low so a synced 1 after reset is a rise seen only by ARM
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= sync_s;
    end
  end

  assign rise_s      = sync_s & ~hist_r;
  assign fall_s      = ~sync_s & hist_r;
  assign active_s    = (state_r == ST_MEASURE) || (state_r == ST_LOCKED);
  assign match_hit_s = (per_cnt_r == CNT_W'(n_i));
  assign match_inc_s = (match_r >= LOCK_V) ? match_r : match_r + MC_W'(1);
  assign locked_s    = (state_s == ST_LOCKED);

  // Next-state, counters and captures; disable overrides everything
  always_comb begin
    state_s   = state_r;
    per_cnt_s = per_cnt_r;
    hi_cnt_s  = hi_cnt_r;
    match_s   = match_r;
    period_s  = period_r;
    high_s    = high_r;
    vld_s     = 1'b0;
    err_ev_s  = 1'b0;
    if (!en_i) begin
      state_s   = ST_IDLE;
      per_cnt_s = CNT_ZERO;
      hi_cnt_s  = CNT_ZERO;
      match_s   = MC_ZERO;
      period_s  = CNT_ZERO;
      high_s    = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_ARM;
        ST_ARM: begin
          if (rise_s) begin
            per_cnt_s = CNT_ONE;
            state_s   = ST_MEASURE;
          end else begin
            per_cnt_s = CNT_ZERO;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (rise_s) begin
            period_s  = per_cnt_r;
            vld_s     = 1'b1;
            per_cnt_s = CNT_ONE;
            if (match_hit_s) begin
              match_s = match_inc_s;
              if (match_inc_s == LOCK_V) begin
                state_s = ST_LOCKED;
              end else begin
                state_s = state_r;
              end
            end else begin
              match_s  = MC_ZERO;
              state_s  = ST_MEASURE;
              err_ev_s = 1'b1;
            end
          end else if (per_cnt_r == CNT_MAX) begin
            // A static divider output is legal for ratios 0 and 1
            state_s   = ST_ARM;
            per_cnt_s = CNT_ZERO;
            match_s   = MC_ZERO;
            err_ev_s  = (n_i >= 4'd2);
          end else begin
            per_cnt_s = per_cnt_r + CNT_ONE;
          end
        end
        default: state_s = ST_IDLE;
      endcase

      if (state_r == ST_IDLE) begin
        hi_cnt_s = CNT_ZERO;
      end else if (rise_s) begin
        hi_cnt_s = CNT_ONE;
      end else if (sync_s && (hi_cnt_r != CNT_MAX)) begin
        hi_cnt_s = hi_cnt_r + CNT_ONE;
      end else begin
        hi_cnt_s = hi_cnt_r;
      end

      if (fall_s && active_s) begin
        high_s = hi_cnt_r;
      end else begin
        high_s = high_r;
      end
    end
  end

  // Sticky error and saturating count; a same-cycle error beats clr_i
  always_comb begin
    err_s     = err_r;
    err_cnt_s = err_cnt_r;
    if (!en_i) begin
      err_s     = 1'b0;
      err_cnt_s = 8'd0;
    end else if (err_ev_s) begin
      err_s     = 1'b1;
      err_cnt_s = clr_i ? 8'd1 : sat_inc8(err_cnt_r);
    end else if (clr_i) begin
      err_s     = 1'b0;
      err_cnt_s = 8'd0;
    end else begin
      err_s     = err_r;
      err_cnt_s = err_cnt_r;
    end
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r   <= ST_IDLE;
      per_cnt_r <= CNT_ZERO;
      hi_cnt_r  <= CNT_ZERO;
      match_r   <= MC_ZERO;
      period_r  <= CNT_ZERO;
      high_r    <= CNT_ZERO;
      vld_r     <= 1'b0;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      per_cnt_r <= per_cnt_s;
      hi_cnt_r  <= hi_cnt_s;
      match_r   <= match_s;
      period_r  <= period_s;
      high_r    <= high_s;
      vld_r     <= vld_s;
      locked_r  <= locked_s;
      err_r     <= err_s;
      err_cnt_r <= err_cnt_s;
    end
  end

  assign period_o     = period_r;
  assign high_o       = high_r;
  assign period_vld_o = vld_r;
  assign locked_o     = locked_r;
  assign err_o        = err_r;
  assign err_cnt_o    = err_cnt_r;

endmodule
